// File: rtl/mdu_stall_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, with stall request.
// Optional MADD/MADDU start ops enabled by defining MDU_MADD_EN.
module mdu_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDop,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_useMD,
    output logic        busy,
    output logic        stall,
    output logic [31:0] E_MDout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_wr;

    logic        is_mul;
    logic        is_div;
    logic        start;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] nxt;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvs;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_s;
    logic [31:0] r_s;

    always_comb begin
        is_mul = (E_MDop == OP_MULT) || (E_MDop == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (E_MDop == OP_MADD) || (E_MDop == OP_MADDU);
`endif
        is_div = (E_MDop == OP_DIV) || (E_MDop == OP_DIVU);
        start  = (state == IDLE) && (is_mul || is_div);
    end

    assign prod_s = $signed({{32{E_A[31]}}, E_A})
                  * $signed({{32{E_B[31]}}, E_B});
    assign prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Signed divide via magnitudes; also keeps INT_MIN/-1 well defined.
    always_comb begin
        a_neg = (E_MDop == OP_DIV) && E_A[31];
        b_neg = (E_MDop == OP_DIV) && E_B[31];
        a_mag = a_neg ? (32'd0 - E_A) : E_A;
        b_mag = b_neg ? (32'd0 - E_B) : E_B;
        dvs   = (E_B == 32'd0) ? 32'd1 : b_mag;
        q_u   = a_mag / dvs;
        r_u   = a_mag % dvs;
        q_s   = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        r_s   = a_neg ? (32'd0 - r_u) : r_u;
    end

    always_comb begin
        case (E_MDop)
            OP_MULT:  nxt = prod_s;
            OP_MULTU: nxt = prod_u;
`ifdef MDU_MADD_EN
            OP_MADD:  nxt = {HI, LO} + prod_s;
            OP_MADDU: nxt = {HI, LO} + prod_u;
`endif
            default:  nxt = {r_s, q_s};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        cnt     <= is_div ? DIV_N : MULT_N;
                        pend    <= nxt;
                        pend_wr <= !(is_div && (E_B == 32'd0));
                    end else if (E_MDop == OP_MTHI) begin
                        HI <= E_A;
                    end else if (E_MDop == OP_MTLO) begin
                        LO <= E_A;
                    end
                end
                RUN: begin
                    if (cnt == 4'd1) begin
                        if (pend_wr) begin
                            HI <= pend[63:32];
                            LO <= pend[31:0];
                        end
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign stall = !reset && D_useMD && (busy || start);

    always_comb begin
        E_MDout = '0;
        if (!reset) begin
            if (E_MDop == OP_MFHI)
                E_MDout = HI;
            else if (E_MDop == OP_MFLO)
                E_MDout = LO;
        end
    end

endmodule

// File: tb/tb_mdu_stall_ctrl.sv
// Directed table-driven bench for mdu_stall_ctrl plus multi-cycle corner
// sequences (ignored ops while busy, async reset mid-divide, MADDU).
module tb_mdu_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_useMD;
    logic        busy;
    logic        stall;
    logic [31:0] E_MDout;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    mdu_stall_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDop  (E_MDop),
        .E_A     (E_A),
        .E_B     (E_B),
        .D_useMD (D_useMD),
        .busy    (busy),
        .stall   (stall),
        .E_MDout (E_MDout),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit st_ok;
        @(negedge clk);
        E_MDop  = v.op;
        E_A     = v.a;
        E_B     = v.b;
        D_useMD = 1'b1;
        #1 chk("stall_at_start", {31'd0, stall}, {31'd0, v.lat > 0});
        @(negedge clk);
        E_MDop = 4'd0;
        E_A    = '0;
        E_B    = '0;
        n      = 0;
        st_ok  = 1'b1;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall !== 1'b1) st_ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_cycles", n, v.lat);
        chk("stall_during_busy", {31'd0, st_ok}, 32'd1);
        chk("stall_after", {31'd0, stall}, 32'd0);
        chk("HI", HI, v.hi);
        chk("LO", LO, v.lo);
        E_MDop = 4'd5;
        #1 chk("MFHI", E_MDout, v.hi);
        E_MDop = 4'd6;
        #1 chk("MFLO", E_MDout, v.lo);
        E_MDop = 4'd0;
        #1 chk("MDout_none", E_MDout, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        vec_t v;

        tbl[0]  = '{4'd1, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1]  = '{4'd2, 32'hFFFFFFFD, 32'd5, 5, 32'h00000004, 32'hFFFFFFF1};
        tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3};
        tbl[4]  = '{4'd3, 32'd5, 32'd0, 10, 32'd1, 32'd3};
        tbl[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000};
        tbl[6]  = '{4'd3, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2};
        tbl[7]  = '{4'd1, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'd0};
        tbl[8]  = '{4'd7, 32'h12345678, 32'd0, 0, 32'h12345678, 32'd0};
        tbl[9]  = '{4'd8, 32'h0000ABCD, 32'd0, 0, 32'h12345678, 32'h0000ABCD};
        tbl[10] = '{4'd15, 32'd9, 32'd9, 0, 32'h12345678, 32'h0000ABCD};

        reset   = 1'b1;
        E_MDop  = '0;
        E_A     = '0;
        E_B     = '0;
        D_useMD = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i]);

        // Ops presented while busy must be ignored.
        @(negedge clk);
        E_MDop = 4'd4;
        E_A    = 32'd9;
        E_B    = 32'd2;
        n      = 0;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            if (busy === 1'b1) n++;
            E_MDop = (i == 2) ? 4'd8 : ((i == 3) ? 4'd1 : 4'd0);
            E_A    = (i == 2) ? 32'hDEADBEEF : 32'd2;
            E_B    = 32'd3;
            @(negedge clk);
        end
        chk("midbusy_cycles", n, 32'd10);
        chk("midbusy_HI", HI, 32'd1);
        chk("midbusy_LO", LO, 32'd4);

        // Async reset on the third busy cycle of a divide.
        E_MDop  = 4'd3;
        E_A     = 32'd100;
        E_B     = 32'd7;
        D_useMD = 1'b1;
        @(negedge clk);
        E_MDop = 4'd0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_HI", HI, 32'd0);
        chk("arst_LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1'b1;
        end
        chk("post_rst_idle", {31'd0, seen}, 32'd0);
        chk("post_rst_HI", HI, 32'd0);
        chk("post_rst_LO", LO, 32'd0);

        // MADDU accumulate across the 64-bit HI/LO boundary.
        v = '{4'd8, 32'hFFFFFFFF, 32'd0, 0, 32'd0, 32'hFFFFFFFF};
        run_vec(v);
`ifdef MDU_MADD_EN
        v = '{4'd10, 32'd1, 32'd1, 5, 32'd1, 32'd0};
`else
        v = '{4'd10, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF};
`endif
        run_vec(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_stall_ctrl.md
Name: mdu_stall_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Sits beside the E-stage ALU and owns the HI/LO registers.
- Accepts mult/div/mfhi/mflo/mthi/mtlo ops from the E-stage.
- Counts out the fixed latency and raises a stall request so the hazard unit freezes PC and the D register and bubbles the D->E register while a D-stage HI/LO instruction would otherwise proceed.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
E_MDop  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, others NONE
E_A  input  32  forwarded rs value
E_B  input  32  forwarded rt value
D_useMD  input  1  D-stage instruction is any HI/LO op (codes 1..10)
busy  output  1  unit is computing
stall  output  1  stall request to hazard unit
E_MDout  output  32  HI when E_MDop==MFHI, LO when MFLO, else 0 (combinational)
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: asynchronous, active-high. Clears cnt, HI, LO, pending result, and the state to IDLE. busy, stall, and E_MDout go to 0 immediately, including mid-operation. A cancelled op never writes HI/LO.
- start = (state==IDLE) && E_MDop in {1,2,3,4} (plus {9,10} with the optional feature).
- States: IDLE, RUN.
  - IDLE->RUN on start. Load cnt = MULT_CYCLES or DIV_CYCLES and latch the 64-bit pending result at that edge.
  - RUN: cnt decrements every cycle.
  - On the edge where cnt==1: {HI,LO} <= pending, cnt <= 0, state <= IDLE.
- Timing for a start op in E at cycle t: busy=1 for cycles t+1..t+N, and new HI/LO are visible at t+N+1.
- busy = (state==RUN).
- stall = D_useMD && (busy || start), combinational. A back-to-back MD op therefore waits in D until busy falls.
- Pending result:
  - MULT: signed 64-bit A*B, {HI,LO}.
  - MULTU: unsigned A*B.
  - DIV: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0): the full DIV_CYCLES busy period still runs; HI/LO remain unchanged.
- MTHI/MTLO in IDLE: HI or LO <= E_A at the next edge; busy stays 0.
- MFHI/MFLO: read the current register with no added latency. A write to HI/LO on the same edge is seen the following cycle.
- Any E_MDop presented while busy is ignored: no state change and no HI/LO write. The hazard unit guarantees this does not occur; the bench checks that it is ignored.
- DIV with INT_MIN/-1: LO=0x80000000, HI=0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: codes 9 MADD and 10 MADDU are start ops. The pending result is {HI,LO} + A*B (signed or unsigned product respectively), latched at start using the HI/LO values of that cycle, with MULT_CYCLES latency. Wrap is modulo 2^64.
- Undefined: codes 9/10 decode as NONE. They do not start, stall, or write, and D_useMD is the hazard unit's concern only.

Test Plan:
- MULT A=0xFFFFFFFD, B=5 at t: busy=1 over t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with the same operands: HI=0x00000004, LO=0xFFFFFFF1. With D_useMD=1, stall=1 during t..t+5 and 0 at t+6.
- DIV A=0xFFFFFFF9 (-7), B=2: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 gives LO=3, HI=1. DIV with B=0 leaves HI/LO unchanged after 10 busy cycles.
- MTHI 0x12345678, then MFHI the next cycle: E_MDout=0x12345678, busy never asserted. An E_MDop=MTLO injected mid-busy leaves LO unchanged.
- Assert reset at cycle 3 of a DIV: busy, stall, HI, and LO drop to 0 without waiting for a clock edge. After release the unit stays IDLE and the cancelled result never appears.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1: after 5 cycles HI=1, LO=0. With the macro undefined, the same op leaves HI/LO and busy unchanged.
